// File: rtl/uart_rx_cfg.sv
// UART receiver with run-time baud/parity selection, 16x oversampling, 2-of-3 majority
// bit decision, and a one-word holding register with overrun/frame/parity/break status.
module uart_rx_cfg #(
    parameter int CLK_FREQ = 50000000,
    parameter int DATA_W   = 8,
    parameter int OVS      = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic [2:0]        Baud_set,
    input  logic [1:0]        parity_mode,
    input  logic              uart_rx,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] Data,
    output logic              rx_valid,
    output logic              rx_done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det,
    output logic              overrun_err
);

    localparam int DIV_W = 16;
    localparam int OVS_W = (OVS > 2) ? $clog2(OVS) : 1;
    localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ / (115200 * OVS));
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ / (57600 * OVS));
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ / (38400 * OVS));
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ / (19200 * OVS));
    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ / (9600 * OVS));

    localparam logic [OVS_W-1:0] TICK_S7   = OVS_W'(7);
    localparam logic [OVS_W-1:0] TICK_S8   = OVS_W'(8);
    localparam logic [OVS_W-1:0] TICK_S9   = OVS_W'(9);
    localparam logic [OVS_W-1:0] TICK_LAST = OVS_W'(OVS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic [DIV_W-1:0] div_sel(input logic [2:0] sel);
        case (sel)
            3'd1:    return DIV_57600;
            3'd2:    return DIV_38400;
            3'd3:    return DIV_19200;
            3'd4:    return DIV_9600;
            default: return DIV_115200;
        endcase
    endfunction

    state_t            state_q;
    logic              sync1_q, sync2_q;
    logic              armed_q;
    logic [2:0]        baud_q;
    logic [1:0]        par_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [OVS_W-1:0]  ovs_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              s7_q, s8_q;
    logic              par_bit_q;
    logic              stop_q;
    logic              fin_q;

    logic tick, tick_last, tick_s9, maj;
    logic par_en, calc_par, pe, brk, consume;

    assign tick      = (state_q != IDLE) && (div_cnt_q == div_sel(baud_q) - DIV_W'(1));
    assign tick_last = tick && (ovs_q == TICK_LAST);
    assign tick_s9   = tick && (ovs_q == TICK_S9);
    // Third sample is the live synchronized line at tick 9.
    assign maj       = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);

    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign calc_par  = (^shift_q) ^ (par_q == 2'b10);
    assign pe        = par_en & (par_bit_q ^ calc_par);
    assign brk       = ~|shift_q & ~(par_en & par_bit_q) & ~stop_q;
    assign consume   = rx_valid & rx_ready;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            armed_q     <= 1'b0;
            baud_q      <= 3'd0;
            par_q       <= 2'd0;
            div_cnt_q   <= '0;
            ovs_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_q      <= 1'b0;
            fin_q       <= 1'b0;
            Data        <= '0;
            rx_valid    <= 1'b0;
            rx_done     <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            rx_done <= 1'b0;
            if (consume)
                rx_valid <= 1'b0;

            if (state_q == IDLE || tick)
                div_cnt_q <= '0;
            else
                div_cnt_q <= div_cnt_q + DIV_W'(1);

            if (tick) begin
                ovs_q <= tick_last ? '0 : ovs_q + OVS_W'(1);
                if (ovs_q == TICK_S7) s7_q <= sync2_q;
                if (ovs_q == TICK_S8) s8_q <= sync2_q;
            end

            case (state_q)
                IDLE: begin
                    baud_q <= Baud_set;
                    par_q  <= parity_mode;
                    ovs_q  <= '0;
                    bit_q  <= '0;
                    fin_q  <= 1'b0;
                    // A start edge only counts once the line has been seen high.
                    if (armed_q && !sync2_q) begin
                        state_q <= START;
                        armed_q <= 1'b0;
                    end else if (sync2_q) begin
                        armed_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s9 && maj)
                        state_q <= IDLE;
                    else if (tick_last)
                        state_q <= DATA;
                end
                DATA: begin
                    if (tick_s9)
                        shift_q <= {maj, shift_q[DATA_W-1:1]};
                    if (tick_last) begin
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            bit_q   <= '0;
                            state_q <= par_en ? PARITY : STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_s9)
                        par_bit_q <= maj;
                    if (tick_last)
                        state_q <= STOP;
                end
                STOP: begin
                    if (sync2_q)
                        armed_q <= 1'b1;
                    // Finish one cycle after the stop-bit decision so flags see stop_q.
                    if (fin_q) begin
                        fin_q      <= 1'b0;
                        state_q    <= IDLE;
                        rx_done    <= 1'b1;
                        parity_err <= pe;
                        frame_err  <= ~stop_q;
                        break_det  <= brk;
                        if (brk) begin
                            overrun_err <= 1'b0;
                        end else if (!rx_valid || consume) begin
                            Data        <= shift_q;
                            rx_valid    <= 1'b1;
                            overrun_err <= 1'b0;
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end else if (tick_s9) begin
                        stop_q <= maj;
                        fin_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter DATA_W, default 8, legal 5..8, data bits per frame.
REQ-003 Parameter OVS, default 16, oversampling ticks per bit.
REQ-004 sysclk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 Baud_set  input  3  baud select: 0=115200, 1=57600, 2=38400, 3=19200, 4=9600, 5..7=115200.
REQ-007 parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-008 uart_rx  input  1  asynchronous serial line, idle high.
REQ-009 rx_ready  input  1  consumer accepts the held word when high while rx_valid is high.
REQ-010 Data  output  DATA_W  received word, LSB first on the line.
REQ-011 rx_valid  output  1  Data holds an unconsumed word.
REQ-012 rx_done  output  1  one-cycle pulse per completed frame, including errored and dropped frames.
REQ-013 parity_err, frame_err, break_det, overrun_err  output  1 each  per-frame status flags.

Function
REQ-014 uart_rx shall pass through a 2-flop synchronizer before any use.
REQ-015 Tick divisor = CLK_FREQ/(baud*OVS), integer truncated (27 for 115200 at defaults); a tick counter shall emit one-cycle ticks.
REQ-016 Baud_set and parity_mode shall be latched only in IDLE; changes mid-frame shall not affect the current frame.
REQ-017 States: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on synchronized falling edge; tick counter restarts at that cycle.
REQ-019 Each bit is resolved by a 2-of-3 majority of samples at ticks 7, 8 and 9 of that bit.
REQ-020 START: majority 1 -> false start, return to IDLE, no rx_done; majority 0 -> DATA.
REQ-021 DATA: shift DATA_W bits LSB first, then go to PARITY if parity is enabled, else STOP.
REQ-022 PARITY: parity_err = received bit XOR computed parity (even: XOR of data bits; odd: its inverse).
REQ-023 STOP: frame_err = 1 if the sampled stop bit is 0.
REQ-024 break_det = 1 when all data bits, the parity bit if present, and the stop bit are all 0.
REQ-025 After the stop-bit majority (tick 9), on the next sysclk: rx_done pulses, flags update, state goes to IDLE.
REQ-026 In the same cycle as REQ-025, if rx_valid is 0, Data is loaded and rx_valid is set.
REQ-027 In the same cycle as REQ-025, if rx_valid is 1, Data is held, the new word is dropped, and overrun_err is set.
REQ-028 Errored frames (parity or frame error) still load Data per REQ-026; break frames do not load Data.
REQ-029 rx_valid clears on the first cycle where rx_valid and rx_ready are both high.
REQ-030 If consumption (REQ-029) and frame completion fall in the same cycle, the new word loads, rx_valid stays 1, and there is no overrun.
REQ-031 The error flags are sticky until the next rx_done, then overwritten with that frame's status.
REQ-032 Return to IDLE after STOP does not require the line to go high first.
REQ-033 A new falling edge is accepted only after a high sample has been seen in IDLE.
REQ-034 IDLE->START shall be reachable from the first cycle after STOP completes; back-to-back frames shall not be lost.

Reset
REQ-035 rst low forces IDLE; tick, bit and shift counters go to 0; Data=0; all status outputs and rx_done go to 0; synchronizer flops go to 1.
REQ-036 Reset asserted mid-frame aborts the frame with no rx_done.
REQ-037 After reset release, the first frame is received normally if its start edge comes at least 2 cycles after release.

Verification
REQ-038 Baud_set=0, no parity, 8680 ns/bit, frames 0xAB, 0xCD, 0xEF with rx_ready=1 -> Data=0xAB, 0xCD, 0xEF in order; three rx_done pulses; all flags 0.
REQ-039 parity_mode=01, frame 0xCD with parity bit 0 (correct value 1) -> Data=0xCD, rx_valid=1, parity_err=1.
REQ-040 Frame 0x55 with stop bit 0 -> frame_err=1, Data=0x55; all-zero frame with stop 0 -> break_det=1, Data unchanged.
REQ-041 2 us low glitch on an idle line at 115200 -> no rx_done; state back to IDLE; next frame 0x3C received correctly.
REQ-042 rx_ready=0, frames 0x11 then 0x22 -> Data=0x11, overrun_err=1 after the second rx_done; rx_ready pulse -> rx_valid=0.
REQ-043 rst low during data bit 3, then high, then frame 0x9A -> no rx_done for the aborted frame; Data=0x9A.
